// File: rtl/call_stack_ctrl_pkg.sv
// call_stack_ctrl_pkg: shared state enum and fetch-control encodings for the call stack controller.
package call_stack_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, PUSH_L, PUSH_H, POP_H, POP_L, POP_LAST, REDIRECT} state_e;
  localparam logic [1:0] PC_NEXT  = 2'b00;
  localparam logic [1:0] PC_ISR   = 2'b10;
  localparam logic [1:0] PC_RET   = 2'b11;
  localparam logic [1:0] POP_NONE = 2'b00;
  localparam logic [1:0] POP_HI   = 2'b11;
  localparam logic [1:0] POP_LO   = 2'b10;
endpackage

// File: rtl/call_stack_ctrl_reg.sv
// call_stack_ctrl_reg: parameterised register with enable and synchronous reset value.
module call_stack_ctrl_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk)
    if (rst) q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: pushes/pops 2-word return addresses on a downward data-memory stack and steers fetch.
module call_stack_ctrl
  import call_stack_ctrl_pkg::*;
#(
  parameter int W    = 16,
  parameter int SIZE = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic [2*W-1:0]  ret_pc_i,
  output logic            mem_wr_o,
  output logic            mem_rd_o,
  output logic [SIZE-1:0] addr_o,
  output logic [W-1:0]    wdata_o,
  output logic [1:0]      pop_l_h_o,
  output logic [1:0]      jump_sel_o,
  output logic            pc_enb_o,
  output logic            busy_o,
  output logic            stk_err_o,
  output logic [SIZE-1:0] sp_o
);
  localparam logic [SIZE-1:0] SP_TOP = '1;
  state_e          state_q;
  logic            is_int_q;
  logic [W-1:0]    ret_hi_q;
  logic [SIZE-1:0] sp_q, sp_d;
  logic            sp_en, push_ok, ret_ok;
  assign push_ok = sp_q >= SIZE'(2);
  assign ret_ok  = sp_q <= SP_TOP - SIZE'(2);
  assign sp_en   = state_q inside {PUSH_L, PUSH_H, POP_H, POP_L};
  assign sp_d    = (state_q == PUSH_L || state_q == PUSH_H) ? sp_q - 1'b1 : sp_q + 1'b1;
  call_stack_ctrl_reg #(.WIDTH(SIZE), .RST_VAL(SP_TOP)) u_sp (
    .clk(clk), .rst(rst), .en_i(sp_en), .d_i(sp_d), .q_o(sp_q)
  );
  // Outputs are registered alongside the transition, so each state's strobes appear while in that state.
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= IDLE;
      is_int_q   <= 1'b0;
      ret_hi_q   <= '0;
      mem_wr_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      pop_l_h_o  <= POP_NONE;
      jump_sel_o <= PC_NEXT;
      stk_err_o  <= 1'b0;
    end else begin
      mem_wr_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
      pop_l_h_o  <= POP_NONE;
      jump_sel_o <= PC_NEXT;
      case (state_q)
        IDLE:
          if (int_i || call_i) begin
            if (push_ok) begin
              state_q  <= PUSH_L;
              is_int_q <= int_i;
              ret_hi_q <= ret_pc_i[2*W-1:W];
              mem_wr_o <= 1'b1;
              addr_o   <= sp_q;
              wdata_o  <= ret_pc_i[W-1:0];
            end else stk_err_o <= 1'b1;
          end else if (ret_i) begin
            if (ret_ok) begin
              state_q  <= POP_H;
              mem_rd_o <= 1'b1;
              addr_o   <= sp_q + 1'b1;
            end else stk_err_o <= 1'b1;
          end
        PUSH_L: begin
          state_q  <= PUSH_H;
          mem_wr_o <= 1'b1;
          addr_o   <= sp_q - 1'b1;
          wdata_o  <= ret_hi_q;
        end
        PUSH_H: begin
          state_q    <= is_int_q ? REDIRECT : IDLE;
          jump_sel_o <= is_int_q ? PC_ISR : PC_NEXT;
        end
        POP_H: begin
          state_q   <= POP_L;
          mem_rd_o  <= 1'b1;
          addr_o    <= sp_q + SIZE'(2);
          pop_l_h_o <= POP_HI;
        end
        POP_L: begin
          state_q   <= POP_LAST;
          pop_l_h_o <= POP_LO;
        end
        POP_LAST: begin
          state_q    <= REDIRECT;
          jump_sel_o <= PC_RET;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy_o   = state_q != IDLE;
  assign pc_enb_o = state_q == IDLE || state_q == REDIRECT;
  assign sp_o     = sp_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: directed stimulus with an expected-event queue checked by a negedge monitor.
module tb_call_stack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic int_r = 1'b0, call_r = 1'b0, ret_r = 1'b0;
  logic [31:0] ret_pc = '0;
  logic mem_wr, mem_rd, pc_enb, busy, stk_err;
  logic [19:0] addr, sp;
  logic [15:0] wdata;
  logic [1:0] pop_l_h, jump_sel;
  logic s_call = 1'b0;
  logic s_wr, s_rd, s_pc_enb, s_busy, s_err;
  logic [3:0] s_addr, s_sp;
  logic [15:0] s_wdata;
  logic [1:0] s_pop, s_jump;
  int checks = 0, failures = 0, s_wr_cnt = 0;
  typedef struct {byte kind; logic [19:0] a; logic [15:0] d;} ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  call_stack_ctrl #(.W(16), .SIZE(20)) dut (
    .clk(clk), .rst(rst), .int_i(int_r), .call_i(call_r), .ret_i(ret_r), .ret_pc_i(ret_pc),
    .mem_wr_o(mem_wr), .mem_rd_o(mem_rd), .addr_o(addr), .wdata_o(wdata), .pop_l_h_o(pop_l_h),
    .jump_sel_o(jump_sel), .pc_enb_o(pc_enb), .busy_o(busy), .stk_err_o(stk_err), .sp_o(sp)
  );

  call_stack_ctrl #(.W(16), .SIZE(4)) dut_s (
    .clk(clk), .rst(rst), .int_i(1'b0), .call_i(s_call), .ret_i(1'b0), .ret_pc_i(32'h0000_0BEE),
    .mem_wr_o(s_wr), .mem_rd_o(s_rd), .addr_o(s_addr), .wdata_o(s_wdata), .pop_l_h_o(s_pop),
    .jump_sel_o(s_jump), .pc_enb_o(s_pc_enb), .busy_o(s_busy), .stk_err_o(s_err), .sp_o(s_sp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input byte k, input logic [19:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input byte k, input logic [19:0] a, input logic [15:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %c addr=%0h data=%0h, none expected", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d) begin
        failures++;
        $display("FAIL event: got %c addr=%0h data=%0h expected %c addr=%0h data=%0h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr && mem_rd) chk("wr_rd_exclusive", 1, 0);
    if (mem_wr) check_ev("W", addr, wdata);
    if (mem_rd) check_ev("R", addr, 16'h0);
    if (pop_l_h != 2'b00) check_ev("P", 20'h0, {14'h0, pop_l_h});
    if (jump_sel != 2'b00) begin
      check_ev("J", 20'h0, {14'h0, jump_sel});
      chk("redirect_pc_enb", {31'h0, pc_enb}, 1);
    end
    if (s_wr) s_wr_cnt++;
  end

  task automatic issue(input logic i, input logic c, input logic r, input logic [31:0] pc);
    @(posedge clk); #1;
    int_r = i; call_r = c; ret_r = r; ret_pc = pc;
    @(posedge clk); #1;
    int_r = 1'b0; call_r = 1'b0; ret_r = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_sp", sp, 32'hFFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_pc_enb", pc_enb, 1);
    chk("rst_stk_err", stk_err, 0);
    chk("rst_jump_sel", jump_sel, 0);
    chk("rst_pop_l_h", pop_l_h, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    // CALL pushes low word first, then high word
    expect_ev("W", 20'hFFFFF, 16'h2345);
    expect_ev("W", 20'hFFFFE, 16'h0001);
    issue(0, 1, 0, 32'h0001_2345);
    chk("call_busy", busy, 1);
    chk("call_pc_enb", pc_enb, 0);
    wait_idle("call");
    chk("call_sp", sp, 32'hFFFFD);
    // RET pops high then low, then redirects to the return address
    expect_ev("R", 20'hFFFFE, 16'h0);
    expect_ev("R", 20'hFFFFF, 16'h0);
    expect_ev("P", 20'h0, 16'h3);
    expect_ev("P", 20'h0, 16'h2);
    expect_ev("J", 20'h0, 16'h3);
    issue(0, 0, 1, 32'h0);
    wait_idle("ret");
    chk("ret_sp", sp, 32'hFFFFF);
    chk("ret_pc_enb", pc_enb, 1);
    // INT beats RET; RET stays held and is served afterwards
    expect_ev("W", 20'hFFFFF, 16'h00AA);
    expect_ev("W", 20'hFFFFE, 16'h0000);
    expect_ev("J", 20'h0, 16'h2);
    expect_ev("R", 20'hFFFFE, 16'h0);
    expect_ev("R", 20'hFFFFF, 16'h0);
    expect_ev("P", 20'h0, 16'h3);
    expect_ev("P", 20'h0, 16'h2);
    expect_ev("J", 20'h0, 16'h3);
    @(posedge clk); #1;
    int_r = 1'b1; ret_r = 1'b1; ret_pc = 32'h0000_00AA;
    @(posedge clk); #1;
    int_r = 1'b0;
    wait_idle("int");
    @(posedge clk); #1;
    ret_r = 1'b0;
    chk("held_ret_busy", busy, 1);
    wait_idle("held_ret");
    chk("int_ret_sp", sp, 32'hFFFFF);
    // underflow: RET on empty stack
    issue(0, 0, 1, 32'h0);
    chk("uflow_busy", busy, 0);
    chk("uflow_stk_err", stk_err, 1);
    chk("uflow_pc_enb", pc_enb, 1);
    chk("uflow_sp", sp, 32'hFFFFF);
    // reset in POP_L abandons the pop and clears the sticky error
    expect_ev("W", 20'hFFFFF, 16'h2345);
    expect_ev("W", 20'hFFFFE, 16'h0001);
    issue(0, 1, 0, 32'h0001_2345);
    wait_idle("call2");
    chk("stk_err_sticky", stk_err, 1);
    expect_ev("R", 20'hFFFFE, 16'h0);
    expect_ev("R", 20'hFFFFF, 16'h0);
    expect_ev("P", 20'h0, 16'h3);
    @(posedge clk); #1;
    ret_r = 1'b1;
    @(posedge clk); #1;
    ret_r = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midpop_busy", busy, 0);
    chk("midpop_pop_l_h", pop_l_h, 0);
    chk("midpop_sp", sp, 32'hFFFFF);
    chk("midpop_stk_err", stk_err, 0);
    chk("midpop_mem_rd", mem_rd, 0);
    // overflow on a 4-bit stack: seven calls bring SP from 15 to 1
    s_wr_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      s_call = 1'b1;
      @(posedge clk); #1;
      s_call = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    chk("small_sp", s_sp, 1);
    chk("small_wr_cnt", s_wr_cnt, 14);
    chk("small_err_clear", s_err, 0);
    @(posedge clk); #1;
    s_call = 1'b1;
    @(posedge clk); #1;
    s_call = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("oflow_wr_cnt", s_wr_cnt, 14);
    chk("oflow_stk_err", s_err, 1);
    chk("oflow_busy", s_busy, 0);
    chk("oflow_sp", s_sp, 1);
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
